// File: rtl/id_ctrl.sv
// -----------------------------------------------------------------------------
// id_ctrl -- instruction-decode control stage.
//
// Purpose:
//   Buffers fetched {inst, pc} packets in a 2-entry FIFO and feeds the
//   external immediate generator combinationally from the queue head.
//   The head is then moved into a registered output slot towards EX. The FIFO
//   and the output slot together hold up to three packets in flight.
//
// Configuration macro:
//   ID_ILLEGAL_CHECK_EN - when defined, an unknown opcode raises ex_illegal
//                         and forces ex_imm to zero. When undefined,
//                         ex_illegal is tied low. The port list does not change.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   if_valid/if_ready    fetch handshake (if_ready = queue has a free slot)
//   if_inst, if_pc       fetched instruction and its PC
//   flush                drop every queued packet and the output packet
//   IMM_TYPE             immediate format of the head instruction
//   IMM_part1/IMM_part2  head inst[11:7] / inst[31:12] (zero when queue empty)
//   ID_IMM               immediate returned by the generator in the same cycle
//   ex_valid/ex_ready    EX handshake
//   ex_pc, ex_imm        registered PC and immediate
//   ex_opcode, ex_rd,
//   ex_rs1, ex_rs2       registered decode fields
//   ex_illegal           registered unknown-opcode flag
// -----------------------------------------------------------------------------
`ifndef CPU_DATA_BITS
`define CPU_DATA_BITS 32
`endif
`ifndef IMM_TYPE_BITS
`define IMM_TYPE_BITS 3
`endif
`ifndef IMM_I_TYPE
`define IMM_I_TYPE 3'd1
`endif
`ifndef IMM_S_TYPE
`define IMM_S_TYPE 3'd2
`endif
`ifndef IMM_B_TYPE
`define IMM_B_TYPE 3'd3
`endif
`ifndef IMM_U_TYPE
`define IMM_U_TYPE 3'd4
`endif
`ifndef IMM_J_TYPE
`define IMM_J_TYPE 3'd5
`endif

module id_ctrl (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_valid,
  output logic                      if_ready,
  input  logic [`CPU_DATA_BITS-1:0] if_inst,
  input  logic [`CPU_DATA_BITS-1:0] if_pc,
  input  logic                      flush,
  output logic [`IMM_TYPE_BITS-1:0] IMM_TYPE,
  output logic [4:0]                IMM_part1,
  output logic [19:0]               IMM_part2,
  input  logic [`CPU_DATA_BITS-1:0] ID_IMM,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [`CPU_DATA_BITS-1:0] ex_pc,
  output logic [`CPU_DATA_BITS-1:0] ex_imm,
  output logic [6:0]                ex_opcode,
  output logic [4:0]                ex_rd,
  output logic [4:0]                ex_rs1,
  output logic [4:0]                ex_rs2,
  output logic                      ex_illegal
);

  // Queue storage is pure data and carries no reset; only pointers/count do.
  logic [`CPU_DATA_BITS-1:0] inst_q [0:1];
  logic [`CPU_DATA_BITS-1:0] pc_q   [0:1];

  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q,  count_d;
  logic       ex_valid_q, ex_valid_d;

  logic [`CPU_DATA_BITS-1:0] ex_pc_q, ex_imm_q;
  logic [6:0]                ex_opcode_q;
  logic [4:0]                ex_rd_q, ex_rs1_q, ex_rs2_q;

  logic [`CPU_DATA_BITS-1:0] head_inst;
  logic [6:0]                head_op;
  logic                      head_vld;
  logic [`IMM_TYPE_BITS-1:0] head_type;
  logic                      head_illegal;
  logic                      push, load;

  assign head_inst = inst_q[rd_ptr_q];
  assign head_op   = head_inst[6:0];
  assign head_vld  = (count_q != 2'd0);

  // Opcode -> immediate format. Unlisted opcodes get the all-zero code,
  // for which the generator returns a zero immediate.
  always_comb begin
    head_type = '0;
    case (head_op)
      7'b0110111, 7'b0010111:             head_type = `IMM_U_TYPE;
      7'b1101111:                         head_type = `IMM_J_TYPE;
      7'b1100111, 7'b0000011, 7'b0010011: head_type = `IMM_I_TYPE;
      7'b0100011:                         head_type = `IMM_S_TYPE;
      7'b1100011:                         head_type = `IMM_B_TYPE;
      default:                            head_type = '0;
    endcase
  end

`ifdef ID_ILLEGAL_CHECK_EN
  // R-type, FENCE and SYSTEM carry no immediate but are still legal.
  always_comb begin
    head_illegal = 1'b1;
    case (head_op)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
      7'b0010011, 7'b0100011, 7'b1100011, 7'b0110011, 7'b0001111,
      7'b1110011: head_illegal = 1'b0;
      default:    head_illegal = 1'b1;
    endcase
  end
`else
  assign head_illegal = 1'b0;
`endif

  assign IMM_TYPE  = head_vld ? head_type         : '0;
  assign IMM_part1 = head_vld ? head_inst[11:7]  : 5'd0;
  assign IMM_part2 = head_vld ? head_inst[31:12] : 20'd0;

  assign if_ready = (count_q < 2'd2);
  assign push     = if_valid & if_ready;
  // The head moves into the output slot whenever that slot is empty or
  // being drained this cycle.
  assign load     = head_vld & (~ex_valid_q | ex_ready);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ex_valid_d = ex_valid_q;
    if (flush) begin
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      count_d    = 2'd0;
      ex_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (load) rd_ptr_d = ~rd_ptr_q;
      case ({push, load})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
      if (load)
        ex_valid_d = 1'b1;
      else if (ex_valid_q & ex_ready)
        ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      ex_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push & ~flush & ~rst) begin
      inst_q[wr_ptr_q] <= if_inst;
      pc_q[wr_ptr_q]   <= if_pc;
    end
  end

  // Output slot: holds steady unless a load happens, so stalled EX sees
  // stable fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_pc_q     <= '0;
      ex_imm_q    <= '0;
      ex_opcode_q <= 7'd0;
      ex_rd_q     <= 5'd0;
      ex_rs1_q    <= 5'd0;
      ex_rs2_q    <= 5'd0;
    end else if (load & ~flush) begin
      ex_pc_q     <= pc_q[rd_ptr_q];
      ex_imm_q    <= head_illegal ? '0 : ID_IMM;
      ex_opcode_q <= head_op;
      ex_rd_q     <= head_inst[11:7];
      ex_rs1_q    <= head_inst[19:15];
      ex_rs2_q    <= head_inst[24:20];
    end
  end

`ifdef ID_ILLEGAL_CHECK_EN
  logic ex_illegal_q;
  always_ff @(posedge clk) begin
    if (rst)
      ex_illegal_q <= 1'b0;
    else if (load & ~flush)
      ex_illegal_q <= head_illegal;
  end
  assign ex_illegal = ex_illegal_q;
`else
  assign ex_illegal = 1'b0;
`endif

  assign ex_valid  = ex_valid_q;
  assign ex_pc     = ex_pc_q;
  assign ex_imm    = ex_imm_q;
  assign ex_opcode = ex_opcode_q;
  assign ex_rd     = ex_rd_q;
  assign ex_rs1    = ex_rs1_q;
  assign ex_rs2    = ex_rs2_q;

endmodule

// File: tb/tb_id_ctrl.sv
`ifndef CPU_DATA_BITS
`define CPU_DATA_BITS 32
`endif
`ifndef IMM_TYPE_BITS
`define IMM_TYPE_BITS 3
`endif
`ifndef IMM_I_TYPE
`define IMM_I_TYPE 3'd1
`endif
`ifndef IMM_S_TYPE
`define IMM_S_TYPE 3'd2
`endif
`ifndef IMM_B_TYPE
`define IMM_B_TYPE 3'd3
`endif
`ifndef IMM_U_TYPE
`define IMM_U_TYPE 3'd4
`endif
`ifndef IMM_J_TYPE
`define IMM_J_TYPE 3'd5
`endif

module tb_id_ctrl;

`ifdef ID_ILLEGAL_CHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, if_valid, flush, ex_ready;
  logic        if_ready, ex_valid, ex_illegal;
  logic [31:0] if_inst, if_pc, ID_IMM, ex_pc, ex_imm;
  logic [`IMM_TYPE_BITS-1:0] IMM_TYPE;
  logic [4:0]  IMM_part1, ex_rd, ex_rs1, ex_rs2;
  logic [19:0] IMM_part2;
  logic [6:0]  ex_opcode;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { logic [31:0] inst; logic [31:0] pc; } pkt_t;
  pkt_t q[$];     // every accepted packet not yet taken by EX, oldest first
  int   shown = 0; // 1 when q[0] sits in the output slot

  always #5 clk = ~clk;

  id_ctrl dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_inst(if_inst), .if_pc(if_pc), .flush(flush), .IMM_TYPE(IMM_TYPE),
    .IMM_part1(IMM_part1), .IMM_part2(IMM_part2), .ID_IMM(ID_IMM),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_illegal(ex_illegal)
  );

  // Immediate generator environment: reassembles the immediate from the parts.
  always_comb begin
    ID_IMM = 32'd0;
    case (IMM_TYPE)
      `IMM_I_TYPE: ID_IMM = {{20{IMM_part2[19]}}, IMM_part2[19:8]};
      `IMM_S_TYPE: ID_IMM = {{20{IMM_part2[19]}}, IMM_part2[19:13], IMM_part1};
      `IMM_B_TYPE: ID_IMM = {{20{IMM_part2[19]}}, IMM_part1[0], IMM_part2[18:13],
                             IMM_part1[4:1], 1'b0};
      `IMM_U_TYPE: ID_IMM = {IMM_part2, 12'd0};
      `IMM_J_TYPE: ID_IMM = {{12{IMM_part2[19]}}, IMM_part2[7:0], IMM_part2[8],
                             IMM_part2[18:9], 1'b0};
      default:     ID_IMM = 32'd0;
    endcase
  end

  function automatic logic [2:0] ref_type(input logic [31:0] i);
    case (i[6:0])
      7'h37, 7'h17:        return `IMM_U_TYPE;
      7'h6F:               return `IMM_J_TYPE;
      7'h67, 7'h03, 7'h13: return `IMM_I_TYPE;
      7'h23:               return `IMM_S_TYPE;
      7'h63:               return `IMM_B_TYPE;
      default:             return 3'd0;
    endcase
  endfunction

  function automatic bit ref_illegal(input logic [31:0] i);
    if (!ILL_EN) return 1'b0;
    case (i[6:0])
      7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h23, 7'h63,
      7'h33, 7'h0F, 7'h73: return 1'b0;
      default:             return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    logic [31:0] s;
    s = {32{i[31]}};
    case (i[6:0])
      7'h67, 7'h03, 7'h13: return {s[19:0], i[31:20]};
      7'h23:               return {s[19:0], i[31:25], i[11:7]};
      7'h63:               return {s[18:0], i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'h37, 7'h17:        return {i[31:12], 12'd0};
      7'h6F:               return {s[10:0], i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:             return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_edge();
    int waiting;
    bit consume, load, accept;
    pkt_t p;
    if (rst || flush) begin
      q.delete();
      shown = 0;
    end else begin
      waiting = q.size() - shown;
      consume = (shown != 0) && ex_ready;
      load    = (waiting > 0) && ((shown == 0) || ex_ready);
      accept  = if_valid && (waiting < 2);
      if (consume) void'(q.pop_front());
      if (accept) begin
        p.inst = if_inst;
        p.pc   = if_pc;
        q.push_back(p);
      end
      shown = load ? 1 : (consume ? 0 : shown);
    end
  endtask

  task automatic check_all();
    int waiting;
    pkt_t h;
    waiting = q.size() - shown;
    chk("ex_valid", {31'd0, ex_valid}, shown);
    chk("if_ready", {31'd0, if_ready}, (waiting < 2) ? 32'd1 : 32'd0);
    if (waiting > 0) begin
      h = q[shown];
      chk("imm_type", {29'd0, IMM_TYPE}, {29'd0, ref_type(h.inst)});
      chk("imm_p1", {27'd0, IMM_part1}, {27'd0, h.inst[11:7]});
      chk("imm_p2", {12'd0, IMM_part2}, {12'd0, h.inst[31:12]});
    end else begin
      chk("imm_type_empty", {29'd0, IMM_TYPE}, 32'd0);
      chk("imm_p2_empty", {12'd0, IMM_part2}, 32'd0);
    end
    if (shown != 0) begin
      h = q[0];
      chk("ex_pc", ex_pc, h.pc);
      chk("ex_imm", ex_imm, ref_illegal(h.inst) ? 32'd0 : ref_imm(h.inst));
      chk("ex_opcode", {25'd0, ex_opcode}, {25'd0, h.inst[6:0]});
      chk("ex_rd", {27'd0, ex_rd}, {27'd0, h.inst[11:7]});
      chk("ex_rs1", {27'd0, ex_rs1}, {27'd0, h.inst[19:15]});
      chk("ex_rs2", {27'd0, ex_rs2}, {27'd0, h.inst[24:20]});
      chk("ex_illegal", {31'd0, ex_illegal}, {31'd0, ref_illegal(h.inst)});
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, "_pc"}, ex_pc, 32'd0);
    chk({tag, "_imm"}, ex_imm, 32'd0);
    chk({tag, "_op"}, {25'd0, ex_opcode}, 32'd0);
    chk({tag, "_regs"}, {17'd0, ex_rd, ex_rs1, ex_rs2}, 32'd0);
    chk({tag, "_ill"}, {31'd0, ex_illegal}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, if_ready}, 32'd1);
    chk({tag, "_type"}, {29'd0, IMM_TYPE}, 32'd0);
  endtask

  logic [6:0] ops [0:11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                              7'h23, 7'h63, 7'h33, 7'h0F, 7'h73, 7'h7F};

  initial begin
    logic [31:0] r;
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    if_inst = 32'd0; if_pc = 32'd0;
    step();
    step();
    rst = 1'b0;
    check_zero_outputs("reset");

    // ADDI x1,x0,-1 at pc 0x100: visible two edges after being offered.
    if_valid = 1'b1; if_inst = 32'hFFF00093; if_pc = 32'h100;
    step();
    if_valid = 1'b0;
    chk("addi_not_yet", {31'd0, ex_valid}, 32'd0);
    step();
    chk("addi_valid", {31'd0, ex_valid}, 32'd1);
    chk("addi_imm", ex_imm, 32'hFFFFFFFF);
    chk("addi_rd", {27'd0, ex_rd}, 32'd1);
    chk("addi_pc", ex_pc, 32'h100);
    step();

    // BEQ -4 followed by LUI x5 back to back.
    if_valid = 1'b1; if_inst = 32'hFE000EE3; if_pc = 32'h200;
    step();
    if_inst = 32'h123452B7; if_pc = 32'h204;
    step();
    if_valid = 1'b0;
    chk("beq_imm", ex_imm, 32'hFFFFFFFC);
    chk("beq_pc", ex_pc, 32'h200);
    step();
    chk("lui_imm", ex_imm, 32'h12345000);
    chk("lui_rd", {27'd0, ex_rd}, 32'd5);
    step();

    // Stalled EX: four offers, three accepted, then drain in order.
    ex_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if_valid = 1'b1; if_inst = 32'h00100013 + (k << 7); if_pc = 32'h300 + 4 * k;
      step();
      if (k == 2) chk("full_not_ready", {31'd0, if_ready}, 32'd0);
    end
    if_valid = 1'b0;
    chk("stall_inflight", q.size(), 32'd3);
    ex_ready = 1'b1;
    step();
    chk("drain_pc1", ex_pc, 32'h304);
    step();
    chk("drain_pc2", ex_pc, 32'h308);
    step();
    step();

    // Flush with queue full and output slot occupied.
    ex_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if_valid = 1'b1; if_inst = 32'h00500093 + (k << 20); if_pc = 32'h400 + 4 * k;
      step();
    end
    flush = 1'b1; if_valid = 1'b1; if_inst = 32'h0FF00093; if_pc = 32'h4F0;
    step();
    flush = 1'b0; if_valid = 1'b0;
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_ready", {31'd0, if_ready}, 32'd1);
    ex_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();

    // Unknown opcode.
    if_valid = 1'b1; if_inst = 32'h0000007F; if_pc = 32'h500;
    step();
    if_valid = 1'b0;
    step();
    chk("ill_flag", {31'd0, ex_illegal}, {31'd0, ILL_EN});
    chk("ill_imm", ex_imm, 32'd0);

    // Reset in the middle of traffic.
    ex_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if_valid = 1'b1; if_inst = 32'hFFF10113 - k; if_pc = 32'h600 + 4 * k;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0; if_valid = 1'b0;
    check_zero_outputs("midrst");
    step();
    chk("post_rst_ready", {31'd0, if_ready}, 32'd1);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      r        = $urandom;
      if_valid = r[0];
      ex_ready = (r[2:1] != 2'b00);
      flush    = (r[8:3] == 6'd0);
      rst      = (r[15:9] == 7'd0);
      if_inst  = {r[31:7], ops[$urandom_range(11, 0)]};
      if_pc    = $urandom;
      step();
    end
    rst = 1'b0; flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ctrl.md
ID_CTRL -- requirements
Module: id_ctrl

Interface
REQ-001 SHALL have no parameters; widths from `CPU_DATA_BITS (32) and `IMM_TYPE_BITS; type codes `IMM_I/S/B/U/J_TYPE from CPU_DEF.svh.
REQ-002 SHALL have these ports; one clock; reset is synchronous and active-high:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- if_valid  in  1  fetch packet valid
- if_ready  out  1  queue can accept
- if_inst  in  32  fetched instruction
- if_pc  in  32  fetched PC
- flush  in  1  discard all held instructions
- IMM_TYPE  out  `IMM_TYPE_BITS  to immediate generator
- IMM_part1  out  5  = head inst[11:7]
- IMM_part2  out  20  = head inst[31:12]
- ID_IMM  in  32  immediate returned by generator, same cycle
- ex_valid  out  1  decoded packet valid
- ex_ready  in  1  EX accepts packet
- ex_pc, ex_imm  out  32 each  registered PC / immediate
- ex_opcode  out  7;  ex_rd, ex_rs1, ex_rs2  out  5 each
- ex_illegal  out  1  unknown opcode flag

Function
REQ-003 SHALL hold a 2-entry FIFO queue of {inst, pc} with wrap-around read/write pointers and a 0..2 count.
REQ-004 SHALL drive if_ready = (count < 2); push on if_valid & if_ready.
REQ-005 SHALL drive IMM_TYPE, IMM_part1, IMM_part2 combinationally from queue head; all-zero when count == 0.
REQ-006 SHALL map head opcode: 0110111/0010111 -> U; 1101111 -> J; 1100111, 0000011, 0010011 -> I; 0100011 -> S; 1100011 -> B; all others -> default code (generator returns 0).
REQ-007 SHALL load the output register (pc, ID_IMM, opcode, rd, rs1, rs2, illegal) and pop the head when count > 0 and (!ex_valid | ex_ready).
REQ-008 SHALL set ex_valid on load; clear it on ex_valid & ex_ready with no concurrent load.
REQ-009 While ex_valid & !ex_ready, all ex_* outputs SHALL stay stable.
REQ-010 Latency: packet pushed at edge N with queue empty and output free SHALL show ex_valid after edge N+1.
REQ-011 Simultaneous push and pop SHALL keep count unchanged; order strictly FIFO.
REQ-012 flush SHALL, at the edge, zero count and pointers and clear ex_valid; a push or load in the same cycle SHALL be dropped.
REQ-013 Total capacity SHALL be 3 packets (2 queued + 1 output register).

Reset
REQ-014 On rst at rising edge: count, pointers = 0; ex_valid = 0; ex_pc, ex_imm, ex_opcode, ex_rd, ex_rs1, ex_rs2, ex_illegal = 0; rst has priority over flush and handshakes.
REQ-015 Reset mid-operation SHALL discard all queued and output packets; if_ready = 1 in the cycle after reset deasserts.

Configuration
REQ-016 Macro ID_ILLEGAL_CHECK_EN defined: opcode outside REQ-006 list and not 0110011/0001111/1110011 SHALL load ex_illegal = 1, ex_imm = 0.
REQ-017 Macro undefined: ex_illegal SHALL be constant 0; port list unchanged.

Verification
REQ-018 Push 0xFFF00093 (ADDI x1,x0,-1), pc 0x100, ex_ready=1 -> ex_valid two edges later, ex_imm 0xFFFFFFFF, ex_rd 1, ex_pc 0x100.
REQ-019 Push 0xFE000EE3 (BEQ -4), then 0x123452B7 (LUI x5) -> ex_imm 0xFFFFFFFC, then 0x12345000, ex_rd 5, in order.
REQ-020 ex_ready=0, push 4 back-to-back -> 3 accepted, if_ready low from 3rd accept; release ex_ready -> 3 packets in FIFO order, no duplicates.
REQ-021 Queue full, ex_valid=1, assert flush with if_valid=1 -> next cycle ex_valid=0, if_ready=1, no stale packet appears later.
REQ-022 Push 0x0000007F with ID_ILLEGAL_CHECK_EN -> ex_illegal=1, ex_imm 0; without macro -> ex_illegal=0; assert rst mid-stream -> all outputs 0 next cycle.
